// File: rtl/glitchcore_pkg.sv
// Shared definitions for the glitchcore Wishbone glitch trigger: register map,
// sequencer state encoding and default counter width.
package glitchcore_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    localparam logic [7:0] STATUS     = 8'h0C;
    localparam logic [7:0] CNT_CTRL   = 8'h10;
    localparam logic [7:0] CNT_TARGET = 8'h14;
    localparam logic [7:0] CNT_VALUE  = 8'h18;
    localparam logic [7:0] DLY_CTRL   = 8'h20;
    localparam logic [7:0] DLY_CYCLES = 8'h24;
    localparam logic [7:0] WID_CTRL   = 8'h30;
    localparam logic [7:0] WID_CYCLES = 8'h34;

    // DONE is not a separate encoding: it is IDLE with the sequencer held disarmed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DELAY = 2'd2,
        ST_PULSE = 2'd3
    } gc_state_e;

    function automatic logic [7:0] reg_offset(input logic [5:0] word_adr);
        return {word_adr, 2'b00};
    endfunction

endpackage

// File: rtl/glitchcore_seq.sv
// Event edge detector, count/delay/width sequencer and registered glitch output.
// With GLITCHCORE_EVENT_SYNC_EN defined, the event input is first passed through a 2-flop synchronizer.
module glitchcore_seq
    import glitchcore_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             event_i,
    input  logic             cnt_en_i,
    input  logic [CNT_W-1:0] cnt_target_i,
    input  logic             dly_en_i,
    input  logic [CNT_W-1:0] dly_cycles_i,
    input  logic             wid_en_i,
    input  logic [CNT_W-1:0] wid_cycles_i,
    output logic             glitch_o,
    output gc_state_e        state_o,
    output logic [CNT_W-1:0] cnt_value_o
);

    gc_state_e        state_q;
    logic             done_q;
    logic             ev_prev_q;
    logic             glitch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tgt_q;
    logic [CNT_W-1:0] dly_q;
    logic [CNT_W-1:0] wid_q;

    logic             ev_s;
    logic             rise;
    logic [CNT_W-1:0] cnt_d;

`ifdef GLITCHCORE_EVENT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], event_i};
        end
    end

    assign ev_s = sync_q[1];
`else
    assign ev_s = event_i;
`endif

    assign rise = ev_s & ~ev_prev_q;

    // Saturating edge count; stays at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            ev_prev_q <= 1'b0;
            glitch_q  <= 1'b0;
            cnt_q     <= '0;
            tgt_q     <= '0;
            dly_q     <= '0;
            wid_q     <= '0;
        end else begin
            ev_prev_q <= ev_s;
            if (!cnt_en_i) begin
                state_q  <= ST_IDLE;
                done_q   <= 1'b0;
                glitch_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!done_q) begin
                            state_q <= ST_COUNT;
                            cnt_q   <= '0;
                            tgt_q   <= cnt_target_i;
                        end
                    end
                    ST_COUNT: begin
                        if (rise) begin
                            cnt_q <= cnt_d;
                            if (cnt_d >= tgt_q) begin
                                state_q <= ST_DELAY;
                                dly_q   <= dly_en_i ? dly_cycles_i : '0;
                            end
                        end
                    end
                    ST_DELAY: begin
                        // Output is raised on PULSE entry, giving D+1 cycles from the final edge.
                        if (dly_q == '0) begin
                            state_q  <= ST_PULSE;
                            wid_q    <= wid_en_i ? wid_cycles_i : '0;
                            glitch_q <= wid_en_i && (wid_cycles_i != '0);
                        end else begin
                            dly_q <= dly_q - CNT_W'(1);
                        end
                    end
                    ST_PULSE: begin
                        if (wid_q <= CNT_W'(1)) begin
                            state_q  <= ST_IDLE;
                            done_q   <= 1'b1;
                            glitch_q <= 1'b0;
                        end else begin
                            wid_q <= wid_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign glitch_o    = glitch_q;
    assign state_o     = state_q;
    assign cnt_value_o = cnt_q;

endmodule

// File: rtl/glitchcore_wb.sv
// Wishbone register file for the glitch trigger; wraps glitchcore_seq.
// GLITCHCORE_EVENT_SYNC_EN (in glitchcore_seq) adds an event input synchronizer.
module glitchcore_wb
    import glitchcore_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        event_in,
    output logic        glitch_out,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o
);

    logic             cnt_ctrl_q;
    logic             dly_ctrl_q;
    logic             wid_ctrl_q;
    logic [CNT_W-1:0] cnt_target_q;
    logic [CNT_W-1:0] dly_cycles_q;
    logic [CNT_W-1:0] wid_cycles_q;
    logic             ack_q;
    logic             ack_d;
    logic [31:0]      dat_q;
    logic [31:0]      dat_d;

    logic [7:0]       off;
    gc_state_e        seq_state;
    logic [CNT_W-1:0] seq_cnt;
    logic             unused_ok;

    assign off       = reg_offset(wb_adr_i[7:2]);
    assign unused_ok = ^{wb_sel_i, wb_cyc_i, wb_adr_i[31:8], wb_adr_i[1:0]};
    assign ack_d     = wb_stb_i & ~ack_q;

    always_comb begin
        dat_d = '0;
        case (off)
            STATUS:     dat_d = 32'(seq_state);
            CNT_CTRL:   dat_d = {31'b0, cnt_ctrl_q};
            CNT_TARGET: dat_d = 32'(cnt_target_q);
            CNT_VALUE:  dat_d = 32'(seq_cnt);
            DLY_CTRL:   dat_d = {31'b0, dly_ctrl_q};
            DLY_CYCLES: dat_d = 32'(dly_cycles_q);
            WID_CTRL:   dat_d = {31'b0, wid_ctrl_q};
            WID_CYCLES: dat_d = 32'(wid_cycles_q);
            default:    dat_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_ctrl_q   <= 1'b0;
            dly_ctrl_q   <= 1'b0;
            wid_ctrl_q   <= 1'b0;
            cnt_target_q <= '0;
            dly_cycles_q <= '0;
            wid_cycles_q <= '0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
        end else begin
            ack_q <= ack_d;
            if (ack_d) begin
                dat_q <= dat_d;
            end
            // Writes commit on every strobed cycle; a held strobe just rewrites the same value.
            if (wb_stb_i && wb_we_i) begin
                case (off)
                    CNT_CTRL:   cnt_ctrl_q   <= wb_dat_i[0];
                    CNT_TARGET: cnt_target_q <= CNT_W'(wb_dat_i);
                    DLY_CTRL:   dly_ctrl_q   <= wb_dat_i[0];
                    DLY_CYCLES: dly_cycles_q <= CNT_W'(wb_dat_i);
                    WID_CTRL:   wid_ctrl_q   <= wb_dat_i[0];
                    WID_CYCLES: wid_cycles_q <= CNT_W'(wb_dat_i);
                    default: ;
                endcase
            end
        end
    end

    glitchcore_seq #(
        .CNT_W (CNT_W)
    ) u_seq (
        .clk_i        (clk),
        .rst_ni       (rst),
        .event_i      (event_in),
        .cnt_en_i     (cnt_ctrl_q),
        .cnt_target_i (cnt_target_q),
        .dly_en_i     (dly_ctrl_q),
        .dly_cycles_i (dly_cycles_q),
        .wid_en_i     (wid_ctrl_q),
        .wid_cycles_i (wid_cycles_q),
        .glitch_o     (glitch_out),
        .state_o      (seq_state),
        .cnt_value_o  (seq_cnt)
    );

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_glitchcore_wb.sv
// Directed bench for glitchcore_wb: register access, shot timing, re-arm, abort and reset.
module tb_glitchcore_wb;
    import glitchcore_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        event_in = 1'b0;
    logic        glitch_out;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic        wb_sel_i = 1'b1;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned pulses = 0;
    int unsigned rise_cyc = 0;
    int unsigned width = 0;
    int unsigned edge_cyc = 0;
    logic        glitch_prev = 1'b0;

    glitchcore_wb #(
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .event_in   (event_in),
        .glitch_out (glitch_out),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_stb_i   (wb_stb_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_ack_o   (wb_ack_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses, records the cycle of each rising edge and the pulse width.
    always @(negedge clk) begin
        if (glitch_out && !glitch_prev) begin
            pulses   = pulses + 1;
            rise_cyc = cyc;
            width    = 0;
        end
        if (glitch_out) width = width + 1;
        glitch_prev = glitch_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat);
        @(negedge clk);
        wb_adr_i = {24'b0, adr};
        wb_dat_i = dat;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge clk);
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] adr, input logic [31:0] exp);
        @(negedge clk);
        wb_adr_i = {24'b0, adr};
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ack"}, {31'b0, wb_ack_o}, 32'd1);
        chk(tag, wb_dat_o, exp);
        @(negedge clk);
        wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_ackfall"}, {31'b0, wb_ack_o}, 32'd0);
    endtask

    task automatic pulse_event();
        @(negedge clk);
        event_in = 1'b1;
        edge_cyc = cyc + 1;
        @(negedge clk);
        event_in = 1'b0;
    endtask

    task automatic run_shot(input string tag, input int unsigned n,
                            input int unsigned lat, input int unsigned wid);
        int unsigned p0;
        p0 = pulses;
        repeat (n) pulse_event();
        for (int i = 0; i < 300 && pulses == p0; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_fire"}, pulses, p0 + 1);
        for (int i = 0; i < 300 && glitch_out; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_end"}, {31'b0, glitch_out}, 32'd0);
        chk({tag, "_lat"}, rise_cyc - edge_cyc, lat);
        chk({tag, "_wid"}, width, wid);
    endtask

    initial begin
        logic [7:0]  offs [8];
        int unsigned p0;
        offs = '{STATUS, CNT_CTRL, CNT_TARGET, CNT_VALUE, DLY_CTRL, DLY_CYCLES, WID_CTRL, WID_CYCLES};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_glitch", {31'b0, glitch_out}, 32'd0);
        chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd_%0h", offs[i]), offs[i], 32'd0);

        // Held strobe: ack toggles 1,0,1 and the repeated write is harmless.
        @(negedge clk);
        wb_adr_i = {24'b0, CNT_TARGET};
        wb_dat_i = 32'd5;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge clk); #1; chk("held_ack0", {31'b0, wb_ack_o}, 32'd1);
        @(posedge clk); #1; chk("held_ack1", {31'b0, wb_ack_o}, 32'd0);
        @(posedge clk); #1; chk("held_ack2", {31'b0, wb_ack_o}, 32'd1);
        @(negedge clk);
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b0;
        rd_chk("held_val", CNT_TARGET, 32'd5);

        wb_wr(8'h1C, 32'hDEAD_BEEF);
        rd_chk("unmapped_1c", 8'h1C, 32'd0);
        wb_wr(CNT_VALUE, 32'h55);
        rd_chk("ro_cntval", CNT_VALUE, 32'd0);

        // Shot 1: target 8, delay 16, width 2.
        wb_wr(CNT_TARGET, 32'd8);
        wb_wr(DLY_CYCLES, 32'h10);
        wb_wr(WID_CYCLES, 32'd2);
        wb_wr(WID_CTRL, 32'hFFFF_FFFF);
        wb_wr(DLY_CTRL, 32'd1);
        wb_wr(CNT_CTRL, 32'd1);
        rd_chk("ctrl_bits", WID_CTRL, 32'd1);
        rd_chk("s1_tgt", CNT_TARGET, 32'd8);
        rd_chk("s1_st_count", STATUS, 32'd1);
        p0 = pulses;
        repeat (7) pulse_event();
        repeat (40) @(posedge clk);
        #1;
        chk("s1_7edges", pulses, p0);
        rd_chk("s1_cnt7", CNT_VALUE, 32'd7);
        run_shot("s1", 1, 17, 2);
        rd_chk("s1_cnt8", CNT_VALUE, 32'd8);
        rd_chk("s1_st_done", STATUS, 32'd0);

        // Shot 2: target 2, delay 24, width 32; then one-shot and re-arm.
        wb_wr(CNT_CTRL, 32'd0);
        wb_wr(DLY_CTRL, 32'd0);
        wb_wr(WID_CTRL, 32'd0);
        wb_wr(CNT_TARGET, 32'd2);
        wb_wr(DLY_CYCLES, 32'h18);
        wb_wr(WID_CYCLES, 32'h20);
        wb_wr(WID_CTRL, 32'd1);
        wb_wr(DLY_CTRL, 32'd1);
        wb_wr(CNT_CTRL, 32'd1);
        run_shot("s2", 2, 25, 32);
        p0 = pulses;
        repeat (3) pulse_event();
        repeat (60) @(posedge clk);
        #1;
        chk("s2_oneshot", pulses, p0);
        wb_wr(CNT_CTRL, 32'd0);
        wb_wr(CNT_CTRL, 32'd1);
        run_shot("s2_rearm", 2, 25, 32);

        // Delay disabled: pulse one cycle after the final edge.
        wb_wr(CNT_CTRL, 32'd0);
        wb_wr(DLY_CTRL, 32'd0);
        wb_wr(DLY_CYCLES, 32'h10);
        wb_wr(CNT_TARGET, 32'd1);
        wb_wr(WID_CYCLES, 32'd4);
        wb_wr(CNT_CTRL, 32'd1);
        run_shot("s3", 1, 1, 4);

        // Width disabled: shot completes without a pulse.
        wb_wr(CNT_CTRL, 32'd0);
        wb_wr(WID_CTRL, 32'd0);
        wb_wr(CNT_CTRL, 32'd1);
        p0 = pulses;
        pulse_event();
        repeat (20) @(posedge clk);
        #1;
        chk("wdis_nopulse", pulses, p0);
        rd_chk("wdis_st_done", STATUS, 32'd0);

        // Abort during PULSE.
        wb_wr(CNT_CTRL, 32'd0);
        wb_wr(DLY_CTRL, 32'd1);
        wb_wr(DLY_CYCLES, 32'd2);
        wb_wr(WID_CTRL, 32'd1);
        wb_wr(WID_CYCLES, 32'h20);
        wb_wr(CNT_CTRL, 32'd1);
        p0 = pulses;
        pulse_event();
        for (int i = 0; i < 100 && pulses == p0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("ab_fire", pulses, p0 + 1);
        rd_chk("ab_st_pulse", STATUS, 32'd3);
        wb_wr(CNT_CTRL, 32'd0);
        chk("ab_hold", {31'b0, glitch_out}, 32'd1);
        @(negedge clk);
        chk("ab_drop", {31'b0, glitch_out}, 32'd0);
        rd_chk("ab_st_idle", STATUS, 32'd0);

        // Reset mid-DELAY.
        wb_wr(CNT_TARGET, 32'd1);
        wb_wr(DLY_CYCLES, 32'h18);
        wb_wr(WID_CYCLES, 32'd4);
        wb_wr(CNT_CTRL, 32'd1);
        pulse_event();
        repeat (3) @(posedge clk);
        rd_chk("rs_st_delay", STATUS, 32'd2);
        p0 = pulses;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rs_glitch", {31'b0, glitch_out}, 32'd0);
        repeat (60) @(posedge clk);
        #1;
        chk("rs_nopulse", pulses, p0);
        rd_chk("rs_st_idle", STATUS, 32'd0);
        rd_chk("rs_cntctrl", CNT_CTRL, 32'd0);
        rd_chk("rs_dly", DLY_CYCLES, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glitchcore_wb.md
Name: glitchcore_wb

Overview:
- Wishbone-controlled glitch trigger generator.
- Counts rising edges on `event_in`. After a programmed number of edges, waits a programmed number of clock cycles, then drives `glitch_out` high for a programmed number of cycles.
- Used as a memory-mapped peripheral on the SoC Wishbone bus for fault-injection experiments.
- One-shot: re-arms only through software.

Parameters:
- CNT_W, 32, width of the count/delay/width registers and counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- event_in  in  1  trigger event input; rising edges are counted.
- glitch_out  out  1  glitch pulse output.
- wb_adr_i  in  32  byte address; only bits [7:2] are decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  1  byte select; ignored (full-word access only).
- wb_stb_i  in  1  strobe; qualifies every access.
- wb_cyc_i  in  1  bus cycle; ignored, `wb_stb_i` alone qualifies an access.
- wb_ack_o  out  1  access acknowledge.

Behaviour:
- Register map (bit0 = enable in each CTRL register; other bits read 0):
  - 0x10 CNT_CTRL (rw)
  - 0x14 CNT_TARGET (rw)
  - 0x18 CNT_VALUE (ro)
  - 0x20 DLY_CTRL (rw)
  - 0x24 DLY_CYCLES (rw)
  - 0x30 WID_CTRL (rw)
  - 0x34 WID_CYCLES (rw)
  - 0x0C STATUS (ro): bits[1:0] = FSM state.
  - Unmapped reads return 0; unmapped writes are dropped.
- Bus timing:
  - Write commits on the clock edge where `wb_stb_i` & `wb_we_i`.
  - `wb_ack_o` is registered: high the cycle after any cycle with `wb_stb_i`=1 and `wb_ack_o`=0.
  - `wb_dat_o` is registered in the same cycle as the ack.
  - `wb_stb_i` held for 2+ cycles repeats the write harmlessly.
- Reset (`rst`=0 at a clock edge): all registers, counters and `wb_ack_o` go to 0; `glitch_out`=0; FSM enters IDLE. Reset mid-pulse drops `glitch_out` on that edge.
- Edge detect: rising edge = `event_in`=1 this cycle and 0 in the previous registered sample.
- FSM states, encoded as IDLE=0, COUNT=1, DELAY=2, PULSE=3:
  - IDLE:
    - CNT_CTRL.en=1 → COUNT, edge count cleared.
    - CNT_CTRL.en=0 → stay in IDLE.
  - COUNT:
    - Each rising edge increments CNT_VALUE.
    - On the edge that makes count ≥ CNT_TARGET: go to DELAY and load the delay counter with DLY_CYCLES, or with 0 if DLY_CTRL.en=0.
    - CNT_TARGET=0 fires on the first edge.
  - DELAY:
    - Stays exactly D cycles, then goes to PULSE.
    - D=0 → straight to PULSE on the next cycle.
    - Latency: `glitch_out` first high D+1 cycles after the clock edge that sampled the final rising edge.
  - PULSE:
    - `glitch_out`=1 for exactly W=WID_CYCLES cycles, only when WID_CTRL.en=1.
    - W=0 or WID_CTRL.en=0 → no pulse.
    - Then go to DONE, which shares encoding 0 with IDLE but is held armed-off.
  - DONE: stays until CNT_CTRL.en is written 0, then returns to IDLE. A fresh write of 1 re-arms.
- Clearing CNT_CTRL.en in any state aborts to IDLE within one cycle and forces `glitch_out`=0.
- Config registers are sampled at stage entry; writes during DELAY or PULSE do not affect the current shot.
- Counters saturate, never wrap. `glitch_out` is registered (glitch-free).

Optional Feature:
- GLITCHCORE_EVENT_SYNC_EN defined: `event_in` passes through a 2-flop synchronizer before edge detection. This adds 2 cycles of latency to all counting and pulse timing.
- Undefined: `event_in` is sampled directly; it must be synchronous to `clk`.

Decomposition:
- Package glitchcore_pkg:
  - register offset constants: CNT_CTRL, CNT_TARGET, CNT_VALUE, DLY_CTRL, DLY_CYCLES, WID_CTRL, WID_CYCLES, STATUS
  - FSM state typedef
  - CNT_W default
- One sub-module, glitchcore_seq: edge detect, FSM and counters.
- Top level holds the Wishbone register file and instantiates glitchcore_seq.

Test Plan:
- Reset, then read all registers → all read 0; `glitch_out`=0; `wb_ack_o` pulses one cycle per strobe.
- Write 0x14=8, 0x24=0x10, 0x34=2, then 0x30=1, 0x20=1, 0x10=1; apply 8 rising edges of `event_in` spaced 2 cycles apart → `glitch_out` high for exactly 2 cycles, starting 17 cycles after the 8th edge is sampled; 7 edges give no pulse.
- Write 0 to 0x10/0x20/0x30, then 0x14=2, 0x24=0x18, 0x34=0x20, re-enable all; apply 2 edges → 32-cycle pulse starting 25 cycles later; further edges give no second pulse until re-armed.
- DLY_CTRL.en=0 with DLY_CYCLES=0x10 → pulse starts 1 cycle after the final edge.
- Clear CNT_CTRL.en during PULSE → `glitch_out` drops next cycle; FSM reads IDLE at 0x0C.
- Assert `rst` (drive low) mid-DELAY → FSM in IDLE; no pulse appears after reset is released.
